// File: rtl/single_cycle_pkg.sv
// Shared definitions for the single-cycle LEGv8 core: opcodes, control bundle,
// decoder and instruction encoders used to build the program ROM.
package single_cycle_pkg;

    localparam logic [10:0] OpLdur = 11'h7C2;
    localparam logic [10:0] OpStur = 11'h7C0;
    localparam logic [10:0] OpAdd  = 11'h458;
    localparam logic [10:0] OpSub  = 11'h658;
    localparam logic [10:0] OpAnd  = 11'h450;
    localparam logic [10:0] OpOrr  = 11'h550;
    localparam logic [7:0]  OpCbz  = 8'hB4;
    localparam logic [5:0]  OpB    = 6'h05;
    localparam logic [8:0]  OpMovz = 9'h1A5;

    localparam logic [4:0] XzrIdx = 5'd31;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOrr, AluPassB} alu_op_e;
    typedef enum logic [1:0] {ImmD, ImmCb, ImmB, ImmMov} imm_sel_e;

    typedef struct packed {
        logic     reg2loc;
        logic     alu_src;
        logic     mem_to_reg;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        logic     uncond;
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
    } ctrl_t;

    // Unrecognised opcodes fall through with every enable low, i.e. a NOP.
    function automatic ctrl_t decode(logic [31:0] instr);
        ctrl_t c;
        c = '0;
        c.alu_op  = AluAdd;
        c.imm_sel = ImmD;
        if (instr[31:21] == OpLdur) begin
            c.alu_src    = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
        end else if (instr[31:21] == OpStur) begin
            c.reg2loc   = 1'b1;
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
        end else if (instr[31:21] == OpAdd) begin
            c.reg_write = 1'b1;
        end else if (instr[31:21] == OpSub) begin
            c.reg_write = 1'b1;
            c.alu_op    = AluSub;
        end else if (instr[31:21] == OpAnd) begin
            c.reg_write = 1'b1;
            c.alu_op    = AluAnd;
        end else if (instr[31:21] == OpOrr) begin
            c.reg_write = 1'b1;
            c.alu_op    = AluOrr;
        end else if (instr[31:24] == OpCbz) begin
            c.reg2loc = 1'b1;
            c.branch  = 1'b1;
            c.alu_op  = AluPassB;
            c.imm_sel = ImmCb;
        end else if (instr[31:26] == OpB) begin
            c.uncond  = 1'b1;
            c.imm_sel = ImmB;
        end else if (instr[31:23] == OpMovz) begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = AluPassB;
            c.imm_sel   = ImmMov;
        end
        return c;
    endfunction

    function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn,
                                          logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm9, logic [4:0] rn,
                                          logic [4:0] rt);
        return {op, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cb(logic [18:0] imm19, logic [4:0] rt);
        return {OpCbz, imm19, rt};
    endfunction

    function automatic logic [31:0] enc_b(logic [25:0] imm26);
        return {OpB, imm26};
    endfunction

    function automatic logic [31:0] enc_iw(logic [1:0] hw, logic [15:0] imm16, logic [4:0] rd);
        return {OpMovz, hw, imm16, rd};
    endfunction

endpackage

// File: rtl/single_cycle_regfile.sv
// 32x64 register file: two combinational read ports, one write port, X31 reads as zero.
module single_cycle_regfile
    import single_cycle_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [63:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [63:0] rd1_o,
    output logic [63:0] rd2_o
);

    logic [63:0] regs [32];

    // No reset: contents deliberately survive between programs.
    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != XzrIdx)) begin
            regs[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == XzrIdx) ? 64'd0 : regs[ra1_i];
    assign rd2_o = (ra2_i == XzrIdx) ? 64'd0 : regs[ra2_i];

endmodule

// File: rtl/single_cycle.sv
// Single-cycle 64-bit LEGv8 core: fetch, decode, execute, memory and writeback
// all complete in one clock.
module single_cycle
    import single_cycle_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startpc,
    output logic [63:0] currentpc,
    output logic [63:0] dmemout
);

    // Word index is addr[63:3] mod DMEM_WORDS, exact for power-of-two depths.
    localparam int unsigned DAw       = $clog2(DMEM_WORDS);
    localparam int unsigned ProgWords = 32;

    // Program 1 at 0x00-0x33, program 2 at 0x34-0x57, corner-case program from 0x58.
    localparam logic [31:0] Prog [ProgWords] = '{
        enc_iw(2'd0, 16'd5, 5'd1),
        enc_d(OpStur, 9'd0, 5'd31, 5'd1),
        enc_d(OpLdur, 9'd0, 5'd31, 5'd2),
        enc_iw(2'd0, 16'd1, 5'd3),
        enc_iw(2'd0, 16'd3, 5'd5),
        enc_r(OpAnd, 5'd31, 5'd2, 5'd4),
        enc_r(OpAdd, 5'd2, 5'd4, 5'd4),
        enc_r(OpSub, 5'd3, 5'd5, 5'd5),
        enc_cb(19'd2, 5'd5),
        enc_b(26'h3FF_FFFD),
        enc_r(OpOrr, 5'd31, 5'd4, 5'd6),
        enc_d(OpStur, 9'd8, 5'd31, 5'd6),
        enc_d(OpLdur, 9'd8, 5'd31, 5'd7),
        enc_iw(2'd3, 16'h1234, 5'd10),
        enc_iw(2'd2, 16'h5678, 5'd11),
        enc_iw(2'd1, 16'h9ABC, 5'd12),
        enc_iw(2'd0, 16'hDEF0, 5'd13),
        enc_r(OpOrr, 5'd11, 5'd10, 5'd14),
        enc_r(OpOrr, 5'd12, 5'd14, 5'd14),
        enc_r(OpOrr, 5'd13, 5'd14, 5'd14),
        enc_d(OpStur, 9'd16, 5'd31, 5'd14),
        enc_d(OpLdur, 9'd16, 5'd31, 5'd15),
        enc_iw(2'd0, 16'd7, 5'd1),
        enc_r(OpAdd, 5'd1, 5'd1, 5'd31),
        enc_r(OpAdd, 5'd1, 5'd31, 5'd2),
        enc_d(OpStur, 9'd8, 5'd31, 5'd2),
        enc_d(OpLdur, 9'd15, 5'd31, 5'd3),
        enc_cb(19'd3, 5'd31),
        enc_iw(2'd0, 16'h0BAD, 5'd20),
        32'd0,
        enc_cb(19'd2, 5'd1),
        enc_b(26'd0)
    };

    logic [63:0] pc_q, pc_d;
    logic [63:0] dmemout_q;
    logic [31:0] instr;
    ctrl_t       ctrl;
    logic [4:0]  ra2;
    logic [63:0] rd1, rd2, imm, alu_b, alu_result, wdata, mem_rdata;
    logic        zero;
    logic [DAw-1:0] didx;
    logic [63:0] dmem [DMEM_WORDS];

    always_comb begin
        instr = '0;
        if ((pc_q[63:2] < 62'(ProgWords)) && (pc_q[63:2] < 62'(IMEM_WORDS))) begin
            instr = Prog[pc_q[6:2]];
        end
    end

    assign ctrl = decode(instr);
    assign ra2  = ctrl.reg2loc ? instr[4:0] : instr[20:16];

    single_cycle_regfile u_regfile (
        .clk_i (CLK),
        .we_i  (ctrl.reg_write & ~resetl),
        .wa_i  (instr[4:0]),
        .wd_i  (wdata),
        .ra1_i (instr[9:5]),
        .ra2_i (ra2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    always_comb begin
        case (ctrl.imm_sel)
            ImmCb:   imm = {{43{instr[23]}}, instr[23:5], 2'b00};
            ImmB:    imm = {{36{instr[25]}}, instr[25:0], 2'b00};
            ImmMov:  imm = 64'(instr[20:5]) << {instr[22:21], 4'b0000};
            default: imm = {{55{instr[20]}}, instr[20:12]};
        endcase
    end

    assign alu_b = ctrl.alu_src ? imm : rd2;

    always_comb begin
        case (ctrl.alu_op)
            AluAdd:   alu_result = rd1 + alu_b;
            AluSub:   alu_result = rd1 - alu_b;
            AluAnd:   alu_result = rd1 & alu_b;
            AluOrr:   alu_result = rd1 | alu_b;
            AluPassB: alu_result = alu_b;
            default:  alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == 64'd0);
    assign didx      = alu_result[3 +: DAw];
    assign mem_rdata = dmem[didx];
    assign wdata     = ctrl.mem_to_reg ? mem_rdata : alu_result;

    always_ff @(posedge CLK) begin
        if (ctrl.mem_write && !resetl) begin
            dmem[didx] <= rd2;
        end
    end

    assign pc_d = (ctrl.uncond || (ctrl.branch && zero)) ? pc_q + imm : pc_q + 64'd4;

    always_ff @(posedge CLK or posedge resetl) begin
        if (resetl) begin
            pc_q      <= startpc;
            dmemout_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (ctrl.mem_read) begin
                dmemout_q <= mem_rdata;
            end
        end
    end

    assign currentpc = pc_q;
    assign dmemout   = dmemout_q;

endmodule

// File: tb/tb_single_cycle.sv
// Bench for single_cycle: an instruction-level interpreter of the ROM programs,
// written from assembly listings, tracks PC and dmemout every cycle.
module tb_single_cycle;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic [63:0] currentpc;
    logic [63:0] dmemout;

    int tests = 0;
    int fails = 0;

    single_cycle #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64)
    ) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .startpc   (startpc),
        .currentpc (currentpc),
        .dmemout   (dmemout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef enum int {KNop, KLdur, KStur, KAdd, KSub, KAnd, KOrr, KCbz, KB, KMovz} kind_e;

    kind_e  p_kind [64];
    int     p_a    [64];
    int     p_b    [64];
    int     p_c    [64];
    longint p_imm  [64];
    int     p_hw   [64];

    logic [63:0] m_pc, m_dout;
    logic [63:0] m_reg [32];
    logic [63:0] m_mem [64];

    task automatic put(input int addr, input kind_e k, input int a, input int b, input int c,
                       input longint imm, input int hw);
        p_kind[addr/4] = k;
        p_a[addr/4]    = a;
        p_b[addr/4]    = b;
        p_c[addr/4]    = c;
        p_imm[addr/4]  = imm;
        p_hw[addr/4]   = hw;
    endtask

    function automatic logic [63:0] rd_reg(input int r);
        return (r == 31) ? 64'd0 : m_reg[r];
    endfunction

    task automatic wr_reg(input int r, input logic [63:0] v);
        if (r != 31) m_reg[r] = v;
    endtask

    function automatic int mem_idx(input logic [63:0] a);
        return int'((a >> 3) % 64);
    endfunction

    task automatic model_exec();
        int          i = 0;
        kind_e       k = KNop;
        logic [63:0] nxt, a, v;
        nxt = m_pc + 64'd4;
        if ((m_pc >> 2) < 64'd64) begin
            i = int'(m_pc >> 2);
            k = p_kind[i];
        end
        case (k)
            KLdur: begin
                a = rd_reg(p_b[i]) + 64'(p_imm[i]);
                v = m_mem[mem_idx(a)];
                wr_reg(p_a[i], v);
                m_dout = v;
            end
            KStur: begin
                a = rd_reg(p_b[i]) + 64'(p_imm[i]);
                m_mem[mem_idx(a)] = rd_reg(p_a[i]);
            end
            KAdd:  wr_reg(p_a[i], rd_reg(p_b[i]) + rd_reg(p_c[i]));
            KSub:  wr_reg(p_a[i], rd_reg(p_b[i]) - rd_reg(p_c[i]));
            KAnd:  wr_reg(p_a[i], rd_reg(p_b[i]) & rd_reg(p_c[i]));
            KOrr:  wr_reg(p_a[i], rd_reg(p_b[i]) | rd_reg(p_c[i]));
            KCbz:  if (rd_reg(p_a[i]) == 64'd0) nxt = m_pc + 64'(p_imm[i] * 4);
            KB:    nxt = m_pc + 64'(p_imm[i] * 4);
            KMovz: wr_reg(p_a[i], 64'(p_imm[i]) << (16 * p_hw[i]));
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model commits at the edge unless reset is high, DUT compared at negedge.
    task automatic step();
        @(posedge CLK);
        if (resetl) begin
            m_pc   = startpc;
            m_dout = 64'd0;
        end else begin
            model_exec();
        end
        @(negedge CLK);
        check("pc", currentpc, m_pc);
        check("dmemout", dmemout, m_dout);
    endtask

    // Called at a negedge; raises reset well away from any rising edge.
    task automatic async_reset(input logic [63:0] pc);
        #2;
        startpc = pc;
        resetl  = 1'b1;
        m_pc    = pc;
        m_dout  = 64'd0;
        #1;
        check("async_reset_pc", currentpc, pc);
        check("async_reset_dmemout", dmemout, 64'd0);
    endtask

    task automatic hold_reset(input logic [63:0] pc);
        startpc = pc;
        step();
    endtask

    task automatic release_reset();
        #1;
        resetl = 1'b0;
    endtask

    task automatic run_until(input logic [63:0] lim, input string tag);
        int n = 0;
        while ((currentpc < lim) && (n < 255)) begin
            step();
            n++;
        end
        tests++;
        assert (n < 255)
        else begin
            fails++;
            $error("FAIL %s_watchdog: ran %0d cycles, required fewer than 255", tag, n);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            put(i * 4, KNop, 0, 0, 0, 0, 0);
        end
        // Program 1: sum 5 three times in a CBZ/B loop, store and reload.
        put(32'h00, KMovz, 1, 0, 0, 5, 0);
        put(32'h04, KStur, 1, 31, 0, 0, 0);
        put(32'h08, KLdur, 2, 31, 0, 0, 0);
        put(32'h0C, KMovz, 3, 0, 0, 1, 0);
        put(32'h10, KMovz, 5, 0, 0, 3, 0);
        put(32'h14, KAnd, 4, 2, 31, 0, 0);
        put(32'h18, KAdd, 4, 4, 2, 0, 0);
        put(32'h1C, KSub, 5, 5, 3, 0, 0);
        put(32'h20, KCbz, 5, 0, 0, 2, 0);
        put(32'h24, KB, 0, 0, 0, -3, 0);
        put(32'h28, KOrr, 6, 4, 31, 0, 0);
        put(32'h2C, KStur, 6, 31, 0, 8, 0);
        put(32'h30, KLdur, 7, 31, 0, 8, 0);
        // Program 2: assemble a 64-bit constant from four MOVZ halfwords.
        put(32'h34, KMovz, 10, 0, 0, 'h1234, 3);
        put(32'h38, KMovz, 11, 0, 0, 'h5678, 2);
        put(32'h3C, KMovz, 12, 0, 0, 'h9ABC, 1);
        put(32'h40, KMovz, 13, 0, 0, 'hDEF0, 0);
        put(32'h44, KOrr, 14, 10, 11, 0, 0);
        put(32'h48, KOrr, 14, 14, 12, 0, 0);
        put(32'h4C, KOrr, 14, 14, 13, 0, 0);
        put(32'h50, KStur, 14, 31, 0, 16, 0);
        put(32'h54, KLdur, 15, 31, 0, 16, 0);
        // Corner cases: XZR write, unaligned load, CBZ both ways, branch-to-self.
        put(32'h58, KMovz, 1, 0, 0, 7, 0);
        put(32'h5C, KAdd, 31, 1, 1, 0, 0);
        put(32'h60, KAdd, 2, 31, 1, 0, 0);
        put(32'h64, KStur, 2, 31, 0, 8, 0);
        put(32'h68, KLdur, 3, 31, 0, 15, 0);
        put(32'h6C, KCbz, 31, 0, 0, 3, 0);
        put(32'h70, KMovz, 20, 0, 0, 'hBAD, 0);
        put(32'h78, KCbz, 1, 0, 0, 2, 0);
        put(32'h7C, KB, 0, 0, 0, 0, 0);

        startpc = 64'd0;
        resetl  = 1'b1;
        m_pc    = 64'd0;
        m_dout  = 64'd0;
        #1;
        check("reset_pc", currentpc, 64'd0);
        check("reset_dmemout", dmemout, 64'd0);
        step();
        release_reset();
        step();
        check("pc_after_1", currentpc, 64'h4);
        step();
        check("pc_after_2", currentpc, 64'h8);

        run_until(64'h34, "prog1");
        check("prog1_result", dmemout, 64'h0000_0000_0000_000F);

        async_reset(64'h34);
        release_reset();
        run_until(64'h58, "prog2");
        check("prog2_result", dmemout, 64'h1234_5678_9ABC_DEF0);

        async_reset(64'h58);
        release_reset();
        repeat (5) step();
        check("xzr_write_and_unaligned_ldur", dmemout, 64'd7);
        step();
        check("cbz_xzr_taken", currentpc, 64'h78);
        step();
        check("cbz_nonzero_not_taken", currentpc, 64'h7C);
        step();
        check("b_to_self", currentpc, 64'h7C);

        // Edges under reset must not commit the MOVZ X1 at 0x00 nor the STUR at 0x2C.
        async_reset(64'h0);
        hold_reset(64'h2C);
        hold_reset(64'h68);
        release_reset();
        step();
        check("no_store_under_reset", dmemout, 64'd7);
        async_reset(64'h60);
        release_reset();
        repeat (3) step();
        check("no_regwrite_under_reset", dmemout, 64'd7);

        for (int it = 0; it < 25; it++) begin
            logic [63:0] spc;
            spc = 64'($urandom_range(0, 66)) << 2;
            async_reset(spc);
            repeat ($urandom_range(0, 2)) hold_reset(spc);
            release_reset();
            repeat ($urandom_range(1, 30)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
